// File: rtl/cache_controller_sa_pkg.sv
// Shared definitions for the set-associative cache controller: FSM encoding,
// address-field width helpers and the saturating counter increment.
package cache_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_FILL,
        S_WRITE_MEM,
        S_DONE
    } state_t;

    function automatic int offset_w(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int index_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int words_per_block, input int num_sets);
        return addr_w - $clog2(words_per_block) - $clog2(num_sets);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_controller_sa_way_store.sv
// One way of the cache: per-set valid bit and tag plus the block words,
// read combinationally and written one word per clock.
module cache_way_store
    import cache_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int TAG_W           = 4,
    parameter int NUM_SETS        = 16,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [index_w(NUM_SETS)-1:0]          rd_index,
    input  logic [offset_w(WORDS_PER_BLOCK)-1:0]  rd_offset,
    output logic                                  rd_valid,
    output logic [TAG_W-1:0]                      rd_tag,
    output logic [DATA_W-1:0]                     rd_data,
    input  logic                                  wr_en,
    input  logic [index_w(NUM_SETS)-1:0]          wr_index,
    input  logic [offset_w(WORDS_PER_BLOCK)-1:0]  wr_offset,
    input  logic [DATA_W-1:0]                     wr_data,
    input  logic                                  set_valid,
    input  logic [TAG_W-1:0]                      wr_tag
);

    localparam int INDEX_W  = index_w(NUM_SETS);
    localparam int OFFSET_W = offset_w(WORDS_PER_BLOCK);

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [DATA_W-1:0]   data_mem [NUM_SETS*WORDS_PER_BLOCK];

    always_comb begin
        valid_d = valid_q;
        if (set_valid) valid_d[wr_index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tag and data arrays need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en)     data_mem[{wr_index, wr_offset}] <= wr_data;
        if (set_valid) tag_mem[wr_index]               <= wr_tag;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/cache_controller_sa.sv
// Write-through, no-write-allocate set-associative cache (1 or 2 ways, LRU)
// between a CPU load/store port and a handshaked word-wide memory.
module cache_controller_sa
    import cache_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 16,
    parameter int WAYS            = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemReadCpu,
    input  logic              MemWriteCpu,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Stall,
    output logic [DATA_W-1:0] DataOut,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck,
    output logic [CNT_W-1:0]  HitCount,
    output logic [CNT_W-1:0]  MissCount
);

    localparam int OFFSET_W = offset_w(WORDS_PER_BLOCK);
    localparam int INDEX_W  = index_w(NUM_SETS);
    localparam int TAG_W    = tag_w(ADDR_W, WORDS_PER_BLOCK, NUM_SETS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;
    logic                victim_q, victim_d;
    logic [NUM_SETS-1:0] lru_q, lru_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [ADDR_W-1:0]   lk_addr;
    logic [OFFSET_W-1:0] lk_offset;
    logic [INDEX_W-1:0]  lk_index;
    logic [TAG_W-1:0]    lk_tag;
    logic [WAYS-1:0]     way_valid, way_hit, wr_en, set_valid, victim_oh;
    logic [TAG_W-1:0]    way_tag  [WAYS];
    logic [DATA_W-1:0]   way_data [WAYS];
    logic                hit, hit_way, victim_sel, cnt_last, wr_req, rd_req;
    logic [DATA_W-1:0]   hit_data, victim_data, wr_data;
    logic [INDEX_W-1:0]  wr_index;
    logic [OFFSET_W-1:0] wr_offset, cnt_next;

    // Lookups use the live CPU address in IDLE and the latched request otherwise.
    assign lk_addr   = (state_q == S_IDLE) ? Address : addr_q;
    assign lk_offset = lk_addr[OFFSET_W-1:0];
    assign lk_index  = lk_addr[OFFSET_W +: INDEX_W];
    assign lk_tag    = lk_addr[ADDR_W-1 -: TAG_W];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_store #(
            .DATA_W(DATA_W), .TAG_W(TAG_W),
            .NUM_SETS(NUM_SETS), .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
        ) u_store (
            .clk(CLK), .rst(RST),
            .rd_index(lk_index), .rd_offset(lk_offset),
            .rd_valid(way_valid[w]), .rd_tag(way_tag[w]), .rd_data(way_data[w]),
            .wr_en(wr_en[w]), .wr_index(wr_index), .wr_offset(wr_offset), .wr_data(wr_data),
            .set_valid(set_valid[w]), .wr_tag(addr_q[ADDR_W-1 -: TAG_W])
        );
        assign way_hit[w] = way_valid[w] && (way_tag[w] == lk_tag);
    end

    assign wr_req      = MemWriteCpu;
    assign rd_req      = MemReadCpu && !MemWriteCpu;
    assign hit         = |way_hit;
    assign hit_way     = (WAYS == 2) && way_hit[WAYS-1];
    assign hit_data    = hit_way ? way_data[WAYS-1] : way_data[0];
    assign victim_sel  = !way_valid[0]                       ? 1'b0 :
                         (WAYS == 2) && !way_valid[WAYS-1]   ? 1'b1 :
                         (WAYS == 2)                         ? lru_q[lk_index] : 1'b0;
    assign victim_data = ((WAYS == 2) && victim_q) ? way_data[WAYS-1] : way_data[0];
    assign victim_oh   = WAYS'(1) << victim_q;
    assign cnt_last    = (cnt_q == OFFSET_W'(WORDS_PER_BLOCK - 1));
    assign cnt_next    = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        victim_d    = victim_q;
        lru_d       = lru_q;
        data_out_d  = data_out_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        wr_en       = '0;
        set_valid   = '0;
        wr_index    = lk_index;
        wr_offset   = lk_offset;
        wr_data     = DataIn;
        Stall       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    Stall       = 1'b1;
                    addr_d      = Address;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = Address;
                    mem_wdata_d = DataIn;
                    state_d     = S_WRITE_MEM;
                    if (hit) begin
                        wr_en           = way_hit;
                        lru_d[lk_index] = ~hit_way;
                        hit_cnt_d       = sat_inc(hit_cnt_q);
                    end else begin
                        miss_cnt_d = sat_inc(miss_cnt_q);
                    end
                end else if (rd_req) begin
                    if (hit) begin
                        data_out_d      = hit_data;
                        lru_d[lk_index] = ~hit_way;
                        hit_cnt_d       = sat_inc(hit_cnt_q);
                    end else begin
                        Stall      = 1'b1;
                        addr_d     = Address;
                        victim_d   = victim_sel;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {Address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        state_d    = S_READ_FILL;
                    end
                end
            end
            S_READ_FILL: begin
                Stall     = 1'b1;
                wr_index  = addr_q[OFFSET_W +: INDEX_W];
                wr_offset = cnt_q;
                wr_data   = MemRData;
                if (MemAck) begin
                    wr_en      = victim_oh;
                    cnt_d      = cnt_next;
                    mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], cnt_next};
                    if (cnt_last) begin
                        set_valid                           = victim_oh;
                        lru_d[addr_q[OFFSET_W +: INDEX_W]]  = ~victim_q;
                        // The requested word may be arriving right now rather than sitting in the store.
                        data_out_d = (cnt_q == addr_q[OFFSET_W-1:0]) ? MemRData : victim_data;
                        mem_req_d  = 1'b0;
                        mem_addr_d = mem_addr_q;
                        state_d    = S_DONE;
                    end
                end
            end
            S_WRITE_MEM: begin
                Stall = 1'b1;
                if (MemAck) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            victim_q    <= 1'b0;
            lru_q       <= '0;
            data_out_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            victim_q    <= victim_d;
            lru_q       <= lru_d;
            data_out_q  <= data_out_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign DataOut   = data_out_q;
    assign MemReq    = mem_req_q;
    assign MemWe     = mem_we_q;
    assign MemAddr   = mem_addr_q;
    assign MemWData  = mem_wdata_q;
    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;

endmodule

// File: tb/tb_cache_controller_sa.sv
// Directed bench for cache_controller_sa with a 2-cycle-ack memory model and a
// read-data scoreboard queue.
module tb_cache_controller_sa;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int MISS_STALL = 1 + 4 * 3;
    localparam int WRITE_STALL = 1 + 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              MemReadCpu, MemWriteCpu;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic              Stall;
    logic [DATA_W-1:0] DataOut;
    logic              MemReq, MemWe, MemAck;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData, MemRData;
    logic [15:0]       HitCount, MissCount;

    logic [DATA_W-1:0] mem     [1024];
    logic [DATA_W-1:0] ref_mem [1024];
    logic [1:0]        wait_cnt;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] last_data;
    int checks, errors, exp_hits, exp_misses;

    cache_controller_sa dut (
        .CLK(CLK), .RST(RST),
        .MemReadCpu(MemReadCpu), .MemWriteCpu(MemWriteCpu),
        .Address(Address), .DataIn(DataIn),
        .Stall(Stall), .DataOut(DataOut),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DATA_W-1:0] preset_word(input int i);
        case (i)
            'h040:   return 32'h1111_0040;
            'h080:   return 32'h2222_0080;
            'h102:   return 32'h4444_0102;
            default: return 32'h0;
        endcase
    endfunction

    // Memory model: acknowledges each word 2 cycles after it is requested.
    assign MemAck   = MemReq && (wait_cnt == 2'd2);
    assign MemRData = mem[MemAddr];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = preset_word(i);
        wait_cnt = '0;
        forever begin
            @(posedge CLK);
            if (MemReq && MemWe && MemAck && !RST) mem[MemAddr] <= MemWData;
            if (RST || !MemReq || MemAck) wait_cnt <= '0;
            else                          wait_cnt <= wait_cnt + 2'd1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters();
        check_output("hit_count", 32'(HitCount), 32'(exp_hits));
        check_output("miss_count", 32'(MissCount), 32'(exp_misses));
    endtask

    // Issues a one-shot read; abort_acks>0 asserts RST after that many fill acks.
    task automatic apply_read(input logic [ADDR_W-1:0] addr, input bit exp_hit, input int abort_acks);
        int acks, stall_cycles, guard;
        logic [DATA_W-1:0] exp;
        exp_q.push_back(ref_mem[addr]);
        MemReadCpu = 1'b1; MemWriteCpu = 1'b0; Address = addr;
        #1;
        check_output("rd_stall_first", 32'(Stall), 32'(!exp_hit));
        if (exp_hit) exp_hits++; else exp_misses++;
        if (exp_hit) begin
            @(negedge CLK);
            MemReadCpu = 1'b0;
        end else begin
            acks = 0; stall_cycles = 1; guard = 0;
            @(negedge CLK);
            while (Stall && guard < 200) begin
                if (abort_acks != 0 && acks == abort_acks) break;
                if (MemAck) begin
                    check_output("fill_addr", 32'(MemAddr), 32'({addr[ADDR_W-1:2], 2'(acks)}));
                    check_output("fill_we", 32'(MemWe), 32'd0);
                    acks++;
                end
                stall_cycles++; guard++;
                @(negedge CLK);
            end
            if (abort_acks != 0) begin
                RST = 1'b1; MemReadCpu = 1'b0;
                @(negedge CLK);
                check_output("abort_memreq", 32'(MemReq), 32'd0);
                check_output("abort_stall", 32'(Stall), 32'd0);
                check_output("abort_dataout", DataOut, 32'd0);
                check_output("abort_misses", 32'(MissCount), 32'd0);
                RST = 1'b0;
                exp_hits = 0; exp_misses = 0; last_data = '0;
                void'(exp_q.pop_back());
                return;
            end
            check_output("fill_done_stall", 32'(Stall), 32'd0);
            check_output("fill_stall_cycles", 32'(stall_cycles), 32'(MISS_STALL));
            check_output("fill_acks", 32'(acks), 32'd4);
            check_output("fill_memreq_off", 32'(MemReq), 32'd0);
            MemReadCpu = 1'b0;
        end
        exp = exp_q.pop_front();
        check_output("rd_dataout", DataOut, exp);
        last_data = exp;
        check_counters();
        if (!exp_hit) @(negedge CLK);
    endtask

    task automatic apply_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                               input bit exp_hit, input bit both, input bit alt_en,
                               input logic [ADDR_W-1:0] alt_addr);
        int acks, stall_cycles, guard;
        MemWriteCpu = 1'b1; MemReadCpu = both; Address = addr; DataIn = data;
        #1;
        check_output("wr_stall_first", 32'(Stall), 32'd1);
        if (exp_hit) exp_hits++; else exp_misses++;
        ref_mem[addr] = data;
        acks = 0; stall_cycles = 1; guard = 0;
        @(negedge CLK);
        if (alt_en) begin
            Address = alt_addr; DataIn = ~data;
        end
        while (Stall && guard < 50) begin
            if (MemAck) begin
                check_output("wr_memwe", 32'(MemWe), 32'd1);
                check_output("wr_memaddr", 32'(MemAddr), 32'(addr));
                check_output("wr_memwdata", MemWData, data);
                acks++;
            end
            stall_cycles++; guard++;
            @(negedge CLK);
        end
        check_output("wr_done_stall", 32'(Stall), 32'd0);
        check_output("wr_stall_cycles", 32'(stall_cycles), 32'(WRITE_STALL));
        check_output("wr_acks", 32'(acks), 32'd1);
        check_output("wr_dataout_kept", DataOut, last_data);
        MemWriteCpu = 1'b0; MemReadCpu = 1'b0;
        check_counters();
        @(negedge CLK);
    endtask

    initial begin
        checks = 0; errors = 0; exp_hits = 0; exp_misses = 0; last_data = '0;
        RST = 1'b1; MemReadCpu = 1'b0; MemWriteCpu = 1'b0; Address = '0; DataIn = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = preset_word(i);

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_output("rst_dataout", DataOut, 32'd0);
        check_output("rst_stall", 32'(Stall), 32'd0);
        check_output("rst_memreq", 32'(MemReq), 32'd0);
        check_output("rst_memwe", 32'(MemWe), 32'd0);
        check_output("rst_memaddr", 32'(MemAddr), 32'd0);
        check_output("rst_memwdata", MemWData, 32'd0);
        check_counters();
        RST = 1'b0;
        @(negedge CLK);
        check_output("idle_stall", 32'(Stall), 32'd0);

        $display("[TB] write miss then read miss");
        apply_write(10'h000, 32'h2805, 1'b0, 1'b0, 1'b0, 10'h000);
        apply_read(10'h000, 1'b0, 0);

        $display("[TB] write hit and read hits");
        apply_write(10'h000, 32'h3008, 1'b1, 1'b0, 1'b0, 10'h000);
        apply_read(10'h000, 1'b1, 0);
        apply_read(10'h001, 1'b1, 0);

        $display("[TB] two-way LRU replacement");
        apply_read(10'h040, 1'b0, 0);
        apply_read(10'h040, 1'b1, 0);
        apply_read(10'h080, 1'b0, 0);
        apply_read(10'h040, 1'b1, 0);
        apply_read(10'h000, 1'b0, 0);

        $display("[TB] simultaneous read/write with address change mid-stall");
        apply_write(10'h005, 32'h30205, 1'b0, 1'b1, 1'b1, 10'h123);
        apply_read(10'h005, 1'b0, 0);

        $display("[TB] reset during fill");
        apply_read(10'h102, 1'b0, 2);
        apply_read(10'h102, 1'b0, 0);

        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_controller_sa.md
# cache_controller_sa

Parametrised set-associative cache controller between the CPU load/store port and a handshaked word-wide main memory. It is the successor to the fixed direct-mapped memory system and adds:
- configurable address/data width, block size, set count and 1- or 2-way associativity with LRU replacement;
- a variable-latency memory req/ack interface;
- hit/miss counters.

Policy is write-through, no-write-allocate, with read-miss block fill.

## Interface
- ADDR_W, 10, CPU/memory word-address width
- DATA_W, 32, word width
- WORDS_PER_BLOCK, 4, words per line (power of 2, ≥2)
- NUM_SETS, 16, sets (power of 2)
- WAYS, 2, associativity (1 or 2 only)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- MemReadCpu  in  1  CPU read request
- MemWriteCpu  in  1  CPU write request
- Address  in  ADDR_W  CPU word address
- DataIn  in  DATA_W  CPU write data
- Stall  out  1  CPU must hold/wait while high
- DataOut  out  DATA_W  read data, registered
- MemReq  out  1  memory request
- MemWe  out  1  1 = write, 0 = read
- MemAddr  out  ADDR_W  memory word address
- MemWData  out  DATA_W  memory write data
- MemRData  in  DATA_W  memory read data, valid with MemAck
- MemAck  in  1  one word transferred this cycle
- HitCount  out  16  saturating hit counter
- MissCount  out  16  saturating miss counter

## Operation
- Address split: offset = low log2(WORDS_PER_BLOCK) bits, index = next log2(NUM_SETS) bits, tag = remainder.
- Per set: WAYS × {valid, tag, block}; one LRU bit (WAYS=2) naming the next victim.
- States: IDLE, READ_FILL, WRITE_MEM, DONE.
- Request priority:
  - Both request inputs high: treated as a write.
  - No request: stay in IDLE.
- IDLE, read hit:
  - Stall=0 in the same cycle.
  - DataOut loads the word at the edge.
  - LRU points at the other way.
  - HitCount+1.
- IDLE, read miss:
  - Latch address; MissCount+1; go to READ_FILL.
  - Victim is the first invalid way (way 0 first), else the LRU way.
- READ_FILL:
  - Drive MemReq=1, MemWe=0, MemAddr={tag,index,cnt}, with cnt running 0..WORDS_PER_BLOCK-1.
  - Each MemAck writes MemRData into the victim word cnt and increments cnt.
  - On the last ack: set valid and tag, point LRU away from the victim, load DataOut with the requested word, go to DONE.
- IDLE, write:
  - Latch address and data.
  - Hit: update the cached word, point LRU away from the hit way, HitCount+1.
  - Miss: no allocation, MissCount+1.
  - Go to WRITE_MEM.
- WRITE_MEM:
  - Drive MemReq=1, MemWe=1, MemAddr and MemWData from the latches until MemAck, then go to DONE.
- DONE: one cycle, Stall=0, request inputs ignored, then IDLE. The CPU drops or changes its request during DONE.
- Stall = (state∈{READ_FILL, WRITE_MEM}) or (IDLE and (write or read miss)).
- DataOut changes only on an IDLE read hit or at fill completion. Writes never change DataOut.
- Address/DataIn changes during a stall are ignored because the request is latched.
- MemAck while MemReq=0 is ignored.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: all valid bits 0, LRU 0, state IDLE, DataOut=0, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, HitCount=0, MissCount=0.
- Stall=0 in IDLE with no request.
- Read hit latency: 0 stall cycles; DataOut valid after the next edge.
- Read miss: Stall is high for 1 + Σ(per-word ack waits) cycles, minimum 1+WORDS_PER_BLOCK with a zero-wait memory. DONE follows with DataOut valid.
- Write (hit or miss): Stall is high for 1 + ack wait cycles (minimum 2), then DONE.
- MemReq/MemAddr are registered-stable through each transfer. A new word address is presented the cycle after each ack.
- RST in any state (including mid-fill or mid-write) takes effect at the next edge:
  - MemReq drops.
  - The partially filled line stays invalid.
  - Memory must tolerate the abandoned request.

## Structure
- Shared package `cache_pkg`: state encoding, derived widths OFFSET_W/INDEX_W/TAG_W as localparam functions, and counter width 16.
- One sub-module, `cache_way_store`: valid/tag/data arrays for one way with a combinational read port and a synchronous word write. Instantiated WAYS times. LRU bits and FSM stay in the top.

## Test plan
Default parameters. Memory model acks 2 cycles after MemReq.
1. Reset: RST=1 for 2 cycles → DataOut=0, Stall=0, MemReq=0, HitCount=MissCount=0.
2. Write miss then read miss:
   - Write 0x000 ← 0x2805 → MemWe=1, MemAddr=0x000, MemWData=0x2805, Stall high until DONE.
   - Read 0x000 → 4-word fill at addresses 0x000..0x003, then DataOut=0x2805.
   - MissCount=2.
3. Write hit and read hits:
   - Write 0x000 ← 0x3008 → memory written, HitCount=1.
   - Read 0x000 → Stall=0 immediately, DataOut=0x3008.
   - Read 0x001 → hit, DataOut=0x00000000.
4. Two-way LRU: fill 0x000 and 0x040 (same index, tags 0 and 1), read 0x040, then read 0x080 → way holding 0x000 evicted; 0x040 read hits, 0x000 read misses.
5. Simultaneous MemReadCpu=MemWriteCpu=1 on 0x005 with 0x30205 → treated as write. Changing Address mid-stall → MemAddr stays 0x005.
6. RST during READ_FILL after 2 acks → next cycle IDLE, MemReq=0. Re-read of the same address misses and refetches all 4 words.
